// File: rtl/ps2_keycode.sv
// PS/2 scan-code set 2 receiver with movement-key tracking.
// Emits the HID code of the held W/A/S/D key for the ball logic.
module ps2_keycode #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic [7:0] scan_code,
  output logic       scan_strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   dat_s;

  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          par;
  logic          par_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          brk;
  logic          brk_n;
  logic          ext;
  logic          ext_n;
  logic [7:0]    key_n;
  logic [7:0]    code_n;
  logic          strobe_n;
  logic          err_n;
  logic [7:0]    mapped;
  logic          odd_ok;

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign odd_ok = ^{shift, par};

  // Bring the keyboard lines into the Clk domain; idle-high after reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Translate the received scan code into the movement-key HID code.
  always_comb begin
    mapped = 8'h00;
    case (shift)
      8'h1D:   mapped = 8'h1A;
      8'h1C:   mapped = 8'h04;
      8'h1B:   mapped = 8'h16;
      8'h23:   mapped = 8'h07;
      default: mapped = 8'h00;
    endcase
  end

  // Frame FSM, watchdog and make/break decode.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    cnt_n     = cnt;
    brk_n     = brk;
    ext_n     = ext;
    key_n     = keycode;
    code_n    = scan_code;
    strobe_n  = 1'b0;
    err_n     = 1'b0;

    if (state != IDLE) begin
      cnt_n = cnt + CW'(1);
    end

    if (fall) begin
      cnt_n = '0;
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
        DATA: begin
          shift_n   = {dat_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s && odd_ok) begin
            strobe_n = 1'b1;
            code_n   = shift;
            unique case (1'b1)
              (shift == 8'hE0): ext_n = 1'b1;
              (shift == 8'hF0): brk_n = 1'b1;
              default: begin
                if (!ext && mapped != 8'h00) begin
                  if (!brk) begin
                    key_n = mapped;
                  end else if (mapped == keycode) begin
                    key_n = 8'h00;
                  end
                end
                brk_n = 1'b0;
                ext_n = 1'b0;
              end
            endcase
          end else begin
            err_n = 1'b1;
            brk_n = 1'b0;
            ext_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && cnt == TO_LAST) begin
      // Keyboard stalled mid-frame: drop the partial byte.
      err_n   = 1'b1;
      state_n = IDLE;
      cnt_n   = '0;
      brk_n   = 1'b0;
      ext_n   = 1'b0;
    end
  end

  // Register FSM state, datapath and outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      par         <= 1'b0;
      cnt         <= '0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      keycode     <= 8'h00;
      scan_code   <= 8'h00;
      scan_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par         <= par_n;
      cnt         <= cnt_n;
      brk         <= brk_n;
      ext         <= ext_n;
      keycode     <= key_n;
      scan_code   <= code_n;
      scan_strobe <= strobe_n;
      frame_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Self-checking bench for ps2_keycode.
// Directed scenarios plus randomized frames against a reference model.
module tb_ps2_keycode;

  localparam int SYNC = 2;
  localparam int TMO  = 300;
  localparam int H    = 6;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic [7:0] scan_code;
  logic       scan_strobe;
  logic       frame_err;

  always #10 Clk = ~Clk;

  ps2_keycode #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .keycode(keycode),
    .scan_code(scan_code),
    .scan_strobe(scan_strobe),
    .frame_err(frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int n_strobe = 0;
  int n_err = 0;
  int n_both = 0;
  logic [7:0] cap_code = 8'h00;
  logic [7:0] cap_key = 8'h00;

  // Pulse monitor: captures outputs on the strobe cycle itself.
  always @(negedge Clk) begin
    if (scan_strobe) begin
      n_strobe++;
      cap_code = scan_code;
      cap_key = keycode;
    end
    if (frame_err) n_err++;
    if (scan_strobe && frame_err) n_both++;
  end

  // Reference model: pending prefix bytes plus held key.
  logic [7:0] m_key = 8'h00;
  logic [7:0] pfx[$];

  function automatic logic [7:0] hid(input logic [7:0] b);
    case (b)
      8'h1D:   return 8'h1A;
      8'h1C:   return 8'h04;
      8'h1B:   return 8'h16;
      8'h23:   return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_accept(input logic [7:0] b);
    bit ex;
    bit br;
    logic [7:0] h;
    if (b == 8'hE0 || b == 8'hF0) begin
      pfx.push_back(b);
      return;
    end
    ex = 0;
    br = 0;
    foreach (pfx[i]) begin
      if (pfx[i] == 8'hE0) ex = 1;
      if (pfx[i] == 8'hF0) br = 1;
    end
    pfx.delete();
    h = hid(b);
    if (ex || h == 8'h00) return;
    if (!br) m_key = h;
    else if (h == m_key) m_key = 8'h00;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input bit flip,
                                        input bit bad_stop);
    logic p;
    p = (~^b) ^ flip;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      PS2_DAT = f[i];
      repeat (H) @(negedge Clk);
      PS2_CLK = 1'b0;
      repeat (H) @(negedge Clk);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (H) @(negedge Clk);
  endtask

  task automatic xfer(input logic [7:0] b, input bit flip, input bit bad_stop);
    send_bits(frame(b, flip, bad_stop), 11);
    if (!flip && !bad_stop) model_accept(b);
    else pfx.delete();
  endtask

  task automatic test_reset();
    @(negedge Clk);
    n_cmp += 4;
    if (keycode !== 8'h00) begin
      n_bad++; $display("FAIL rst_keycode got=%h exp=00", keycode);
    end
    if (scan_code !== 8'h00) begin
      n_bad++; $display("FAIL rst_scan_code got=%h exp=00", scan_code);
    end
    if (scan_strobe !== 1'b0) begin
      n_bad++; $display("FAIL rst_strobe got=%b exp=0", scan_strobe);
    end
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_make();
    int s0;
    int e0;
    s0 = n_strobe;
    e0 = n_err;
    xfer(8'h1C, 0, 0);
    n_cmp += 4;
    if (n_strobe - s0 !== 1) begin
      n_bad++; $display("FAIL make_strobes got=%0d exp=1", n_strobe - s0);
    end
    if (cap_code !== 8'h1C) begin
      n_bad++; $display("FAIL make_code got=%h exp=1c", cap_code);
    end
    if (cap_key !== 8'h04) begin
      n_bad++; $display("FAIL make_key_same_cycle got=%h exp=04", cap_key);
    end
    if (n_err - e0 !== 0) begin
      n_bad++; $display("FAIL make_err got=%0d exp=0", n_err - e0);
    end
  endtask

  task automatic test_release();
    int s0;
    s0 = n_strobe;
    xfer(8'hF0, 0, 0);
    n_cmp++;
    if (keycode !== 8'h04) begin
      n_bad++; $display("FAIL rel_after_f0 got=%h exp=04", keycode);
    end
    xfer(8'h1C, 0, 0);
    n_cmp += 2;
    if (keycode !== 8'h00) begin
      n_bad++; $display("FAIL rel_key got=%h exp=00", keycode);
    end
    if (n_strobe - s0 !== 2) begin
      n_bad++; $display("FAIL rel_strobes got=%0d exp=2", n_strobe - s0);
    end
  endtask

  task automatic test_last_wins();
    xfer(8'h1D, 0, 0);
    n_cmp++;
    if (keycode !== 8'h1A) begin
      n_bad++; $display("FAIL lw_w got=%h exp=1a", keycode);
    end
    xfer(8'h23, 0, 0);
    n_cmp++;
    if (keycode !== 8'h07) begin
      n_bad++; $display("FAIL lw_d got=%h exp=07", keycode);
    end
    xfer(8'hF0, 0, 0);
    xfer(8'h1D, 0, 0);
    n_cmp++;
    if (keycode !== 8'h07) begin
      n_bad++; $display("FAIL lw_w_rel got=%h exp=07", keycode);
    end
  endtask

  task automatic test_parity_err();
    int s0;
    int e0;
    xfer(8'hF0, 0, 0);
    xfer(8'h23, 0, 0);
    s0 = n_strobe;
    e0 = n_err;
    xfer(8'h1C, 1, 0);
    n_cmp += 3;
    if (n_err - e0 !== 1) begin
      n_bad++; $display("FAIL par_err got=%0d exp=1", n_err - e0);
    end
    if (n_strobe - s0 !== 0) begin
      n_bad++; $display("FAIL par_strobe got=%0d exp=0", n_strobe - s0);
    end
    if (keycode !== 8'h00) begin
      n_bad++; $display("FAIL par_key got=%h exp=00", keycode);
    end
    xfer(8'h1B, 0, 0);
    n_cmp++;
    if (keycode !== 8'h16) begin
      n_bad++; $display("FAIL par_recover got=%h exp=16", keycode);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int e0;
    int got;
    f = frame(8'h55, 0, 0);
    send_bits(f, 4);
    e0 = n_err;
    @(negedge Clk);
    PS2_DAT = f[4];
    repeat (H) @(negedge Clk);
    PS2_CLK = 1'b0;
    got = -1;
    for (int c = 1; c <= SYNC + TMO + 40; c++) begin
      @(negedge Clk);
      if (c == H) PS2_CLK = 1'b1;
      if (frame_err && got < 0) got = c;
    end
    PS2_DAT = 1'b1;
    pfx.delete();
    n_cmp += 2;
    if (got !== SYNC + 1 + TMO) begin
      n_bad++; $display("FAIL tmo_latency got=%0d exp=%0d", got, SYNC + 1 + TMO);
    end
    if (n_err - e0 !== 1) begin
      n_bad++; $display("FAIL tmo_pulses got=%0d exp=1", n_err - e0);
    end
    xfer(8'h23, 0, 0);
    n_cmp++;
    if (keycode !== 8'h07) begin
      n_bad++; $display("FAIL tmo_recover got=%h exp=07", keycode);
    end
  endtask

  task automatic test_extended();
    int s0;
    s0 = n_strobe;
    xfer(8'hE0, 0, 0);
    xfer(8'h1D, 0, 0);
    n_cmp += 3;
    if (keycode !== 8'h07) begin
      n_bad++; $display("FAIL ext_key got=%h exp=07", keycode);
    end
    if (n_strobe - s0 !== 2) begin
      n_bad++; $display("FAIL ext_strobes got=%0d exp=2", n_strobe - s0);
    end
    if (cap_code !== 8'h1D) begin
      n_bad++; $display("FAIL ext_code got=%h exp=1d", cap_code);
    end
  endtask

  task automatic test_start_err();
    int e0;
    int s0;
    e0 = n_err;
    s0 = n_strobe;
    @(negedge Clk);
    PS2_DAT = 1'b1;
    repeat (H) @(negedge Clk);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge Clk);
    PS2_CLK = 1'b1;
    repeat (H) @(negedge Clk);
    n_cmp += 3;
    if (n_err - e0 !== 1) begin
      n_bad++; $display("FAIL start_err got=%0d exp=1", n_err - e0);
    end
    if (n_strobe - s0 !== 0) begin
      n_bad++; $display("FAIL start_strobe got=%0d exp=0", n_strobe - s0);
    end
    if (keycode !== m_key) begin
      n_bad++; $display("FAIL start_key got=%h exp=%h", keycode, m_key);
    end
  endtask

  task automatic test_reset_mid();
    xfer(8'h1C, 0, 0);
    send_bits(frame(8'h1D, 0, 0), 5);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp += 4;
    if (keycode !== 8'h00) begin
      n_bad++; $display("FAIL mid_rst_key got=%h exp=00", keycode);
    end
    if (scan_code !== 8'h00) begin
      n_bad++; $display("FAIL mid_rst_code got=%h exp=00", scan_code);
    end
    if (scan_strobe !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_strobe got=%b exp=0", scan_strobe);
    end
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_err got=%b exp=0", frame_err);
    end
    Reset = 1'b1;
    m_key = 8'h00;
    pfx.delete();
    xfer(8'h1C, 0, 0);
    n_cmp++;
    if (keycode !== 8'h04) begin
      n_bad++; $display("FAIL mid_rst_recover got=%h exp=04", keycode);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit flip;
    bit bst;
    bit ok;
    int s0;
    int e0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'h1C;
        1:       b = 8'h1D;
        2:       b = 8'h1B;
        3:       b = 8'h23;
        4:       b = 8'hF0;
        5:       b = 8'hF0;
        6:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      flip = ($urandom_range(0, 7) == 0);
      bst = ($urandom_range(0, 9) == 0);
      ok = !flip && !bst;
      s0 = n_strobe;
      e0 = n_err;
      xfer(b, flip, bst);
      n_cmp += 3;
      if (n_strobe - s0 !== (ok ? 1 : 0)) begin
        n_bad++;
        $display("FAIL rnd%0d_strobe b=%h got=%0d exp=%0d", i, b, n_strobe - s0, ok ? 1 : 0);
      end
      if (n_err - e0 !== (ok ? 0 : 1)) begin
        n_bad++;
        $display("FAIL rnd%0d_err b=%h got=%0d exp=%0d", i, b, n_err - e0, ok ? 0 : 1);
      end
      if (keycode !== m_key) begin
        n_bad++;
        $display("FAIL rnd%0d_key b=%h got=%h exp=%h", i, b, keycode, m_key);
      end
      if (ok) begin
        n_cmp += 2;
        if (cap_code !== b) begin
          n_bad++; $display("FAIL rnd%0d_code got=%h exp=%h", i, cap_code, b);
        end
        if (cap_key !== m_key) begin
          n_bad++; $display("FAIL rnd%0d_cap_key got=%h exp=%h", i, cap_key, m_key);
        end
      end
    end
    n_cmp++;
    if (n_both !== 0) begin
      n_bad++; $display("FAIL strobe_err_overlap got=%0d exp=0", n_both);
    end
  endtask

  initial begin
    Reset = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (3) @(negedge Clk);
    test_reset();
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    test_make();
    model_accept(8'h1C);
    test_release();
    model_accept(8'hF0);
    model_accept(8'h1C);
    test_last_wins();
    test_parity_err();
    m_key = 8'h16;
    pfx.delete();
    test_timeout();
    m_key = 8'h07;
    test_extended();
    test_start_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
